// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the tx buffer and the serializer, plus the serial line itself.
// The buffer side drives tx_start/tx_data; the serializer drives tx_busy and tx.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx;

  modport master (output tx_start, tx_data, input tx_busy, tx);
  modport slave  (input tx_start, tx_data, output tx_busy, tx);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Start bit appears on tx the cycle after acceptance; tx_start is dropped while tx_busy.
module uart_tx_serializer #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          tx_q;
  logic          tx_nxt;
  logic          tx_busy;
  logic          bit_end;
  logic          accept;

  assign bit_end = (baud_cnt == BIT_LAST);
  assign accept  = bus.tx_start && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.tx_start) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end && stop_idx == STOP_LAST) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // tx is registered, so pick the bit that the *next* state will be sending.
  always_comb begin
    tx_nxt  = 1'b1;
    tx_busy = !rst && ((state != S_IDLE) || bus.tx_start);
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = (state == S_DATA && bit_end) ? shift_reg[1] : shift_reg[0];
      S_PARITY: tx_nxt = par_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_q <= tx_nxt;
      if (state == S_IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
      if (accept) begin
        shift_reg <= bus.tx_data;
        par_bit   <= (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
      end
      if (state == S_DATA && bit_end) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end
      if (state == S_STOP && bit_end) begin
        stop_idx <= (stop_idx == STOP_LAST) ? 1'b0 : 1'b1;
      end
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = tx_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four serializers (P0/S1, P2/S1, P1/S1, P2/S2) share one stimulus stream.
// CLKS_PER_BIT = 4; cycle 0 of each capture is the accept cycle.
module tb_uart_tx_serializer;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data;

  int vectors;
  int miscompares;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  assign if0.tx_start = start;
  assign if1.tx_start = start;
  assign if2.tx_start = start;
  assign if3.tx_start = start;
  assign if0.tx_data  = data;
  assign if1.tx_data  = data;
  assign if2.tx_data  = data;
  assign if3.tx_data  = data;

  uart_tx_serializer #(.CLK_HZ(1000), .BAUD(250), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_serializer #(.CLK_HZ(1000), .BAUD(250), .PARITY(2), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx_serializer #(.CLK_HZ(1000), .BAUD(250), .PARITY(1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx_serializer #(.CLK_HZ(1000), .BAUD(250), .PARITY(2), .STOP_BITS(2))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic [3:0] txs;
  logic [3:0] busys;
  assign txs   = {if3.tx, if2.tx, if1.tx, if0.tx};
  assign busys = {if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};

  logic [3:0] txlog [0:127];
  logic [3:0] bzlog [0:127];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; inputs change there, outputs are logged at negedge.
  task automatic run(input logic [7:0] d, input int ncap, input int s2_cyc,
                     input logic [7:0] d2, input int chg_cyc, input int rst_cyc);
    for (int c = 0; c < ncap; c++) begin
      start = (c == 0) || (c == s2_cyc);
      rst   = (c == rst_cyc);
      if (c == 0) data = d;
      else if (c == s2_cyc) data = d2;
      else if (chg_cyc >= 0 && c >= chg_cyc) data = 8'hFF;
      @(negedge clk);
      txlog[c] = txs;
      bzlog[c] = busys;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int busy_cnt(input int dut, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(bzlog[i][dut]);
    return n;
  endfunction

  function automatic int tx_cnt(input int dut, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(txlog[i][dut]);
    return n;
  endfunction

  // pat[b] is line bit b; each bit must hold for all 4 of its cycles.
  task automatic chk_frame(input string tag, input int dut, input int c0,
                           input logic [11:0] pat, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      logic [3:0] got;
      for (int k = 0; k < 4; k++) got[k] = txlog[c0 + 4*b + k][dut];
      check($sformatf("%s bit%0d", tag, b), {28'd0, got}, {28'd0, {4{pat[b]}}});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h41;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst tx c%0d", i), {31'd0, if0.tx}, 32'd1);
      check($sformatf("rst busy c%0d", i), {31'd0, if0.tx_busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("post-rst tx c%0d", i), {31'd0, if0.tx}, 32'd1);
      check($sformatf("post-rst busy c%0d", i), {31'd0, if0.tx_busy}, 32'd0);
      @(posedge clk);
      #1;
    end

    // single 8'h41 frame
    run(8'h41, 50, -1, 8'h00, -1, -1);
    check("single idle tx in accept", {31'd0, txlog[0][0]}, 32'd1);
    chk_frame("single41", 0, 1, 12'b0010_1000_0010, 10);
    check("single busy cycles", busy_cnt(0, 0, 49), 32'd41);
    check("single busy last", {31'd0, bzlog[40][0]}, 32'd1);
    check("single busy drop", {31'd0, bzlog[41][0]}, 32'd0);
    gap(30);

    // back-to-back: 8'h42 in first idle cycle
    run(8'h41, 90, 41, 8'h42, -1, -1);
    chk_frame("b2b first", 0, 1, 12'b0010_1000_0010, 10);
    check("b2b gap high", tx_cnt(0, 37, 41), 32'd5);
    chk_frame("b2b second", 0, 42, 12'b0010_1000_0100, 10);
    check("b2b busy accept2", {31'd0, bzlog[41][0]}, 32'd1);
    check("b2b busy2 cycles", busy_cnt(0, 41, 89), 32'd41);
    check("b2b busy2 drop", {31'd0, bzlog[82][0]}, 32'd0);
    gap(30);

    // start during data bit 3 is ignored
    run(8'h41, 70, 18, 8'h43, -1, -1);
    chk_frame("drop", 0, 1, 12'b0010_1000_0010, 10);
    check("drop busy cycles", busy_cnt(0, 0, 69), 32'd41);
    check("drop no 2nd frame", tx_cnt(0, 41, 69), 32'd29);
    gap(30);

    // formats with 8'h43
    run(8'h43, 60, -1, 8'h00, -1, -1);
    chk_frame("p0 43", 0, 1, 12'b0010_1000_0110, 10);
    chk_frame("even", 1, 1, 12'b0110_1000_0110, 11);
    chk_frame("odd", 2, 1, 12'b0100_1000_0110, 11);
    chk_frame("even2stop", 3, 1, 12'b1110_1000_0110, 12);
    check("even busy cycles", busy_cnt(1, 0, 59), 32'd45);
    check("2stop busy cycles", busy_cnt(3, 0, 59), 32'd49);
    check("2stop busy last", {31'd0, bzlog[48][3]}, 32'd1);
    check("2stop busy drop", {31'd0, bzlog[49][3]}, 32'd0);
    check("2stop idle tx", {31'd0, txlog[49][3]}, 32'd1);
    gap(30);

    // reset during data bit 3 (cycles 17..20)
    run(8'h41, 30, -1, 8'h00, -1, 18);
    check("midrst tx before", {31'd0, txlog[18][0]}, 32'd0);
    check("midrst busy in rst", {31'd0, bzlog[18][0]}, 32'd0);
    check("midrst tx after", {31'd0, txlog[19][0]}, 32'd1);
    check("midrst busy after", {31'd0, bzlog[19][0]}, 32'd0);
    check("midrst stays idle busy", busy_cnt(0, 19, 29), 32'd0);
    check("midrst stays idle tx", tx_cnt(0, 19, 29), 32'd11);
    gap(5);
    run(8'h44, 50, -1, 8'h00, -1, -1);
    chk_frame("after rst 44", 0, 1, 12'b0010_1000_1000, 10);
    check("after rst busy", busy_cnt(0, 0, 49), 32'd41);
    gap(30);

    // data changes after accept
    run(8'h41, 50, -1, 8'h00, 1, -1);
    chk_frame("latch", 0, 1, 12'b0010_1000_0010, 10);
    check("latch busy", busy_cnt(0, 0, 49), 32'd41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
